pixel_scheduler: RTL and testbench

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

---
 rtl/pixel_scheduler.sv | 134 +++++++++++++
 tb/tb_pixel_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
// Raster scanout timing generator that shares one single-port frame buffer between
// scanout reads and a writer port. Each pixel comes out two clock edges after its pix_en.
module pixel_scheduler #(
    parameter int unsigned H_ACTIVE     = 480,
    parameter int unsigned H_TOTAL      = 525,
    parameter int unsigned H_SYNC_START = 482,
    parameter int unsigned H_SYNC_END   = 523,
    parameter int unsigned V_ACTIVE     = 272,
    parameter int unsigned V_TOTAL      = 288,
    parameter int unsigned V_SYNC_START = 274,
    parameter int unsigned V_SYNC_END   = 284,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pix_en,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_color,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic [2:0]        color,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);
    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, state_nx;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] scan_addr;
    logic              h_last, v_last, active, pix, scan_rd, in_range;
    logic              h_sync_on, v_sync_on;
    logic              p_valid, p_de, p_hs, p_vs, p_fs;

    always_comb begin
        h_last    = (h_cnt == HW'(H_TOTAL - 1));
        v_last    = (v_cnt == VW'(V_TOTAL - 1));
        active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        h_sync_on = (h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END));
        v_sync_on = (v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END));
        pix       = (state == SCAN) && pix_en;
        scan_rd   = pix && active;
        in_range  = ({1'b0, wr_addr} < FB_SIZE);
    end

    // The pix_en that leaves IDLE only arms the scan; the next pix_en is pixel (0,0).
    always_comb begin
        state_nx  = state;
        wr_ack    = 1'b0;
        wr_err    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: if (pix_en && enable) state_nx = SCAN;
            SCAN: if (pix && h_last && v_last && !enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!reset) begin
            if (scan_rd) begin
                mem_addr = scan_addr;
            end else if (wr_req) begin
                wr_ack = 1'b1;
                if (in_range) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_color;
                end else begin
                    wr_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            scan_addr   <= '0;
            p_valid     <= 1'b0;
            p_de        <= 1'b0;
            p_hs        <= 1'b1;
            p_vs        <= 1'b1;
            p_fs        <= 1'b0;
            color       <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state   <= state_nx;
            p_valid <= pix;
            if (pix) begin
                p_de <= active;
                p_hs <= ~h_sync_on;
                p_vs <= ~v_sync_on;
                p_fs <= (h_cnt == '0) && (v_cnt == '0);
                if (active) scan_addr <= scan_addr + ADDR_W'(1);
                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt     <= '0;
                        scan_addr <= '0;
                    end else begin
                        v_cnt <= v_cnt + VW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
            // Second stage: read data for the pixel issued last cycle is now on mem_rdata.
            frame_start <= p_valid & p_fs;
            if (p_valid) begin
                de    <= p_de;
                color <= p_de ? mem_rdata : 3'd0;
                hsync <= p_hs;
                vsync <= p_vs;
            end
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler on a reduced raster: a frame-level reference model checks
// every output each cycle, with literal expectations for raster shape and write handling.
module tb_pixel_scheduler;
    localparam int HA = 8, HT = 14, HSS = 9, HSE = 12;
    localparam int VA = 5, VT = 9, VSS = 6, VSE = 8;
    localparam int AW = 6;
    localparam int N  = HT * VT;
    localparam int FB = HA * VA;

    logic          clk = 1'b0;
    logic          reset, enable, pix_en, wr_req;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_color;
    logic          wr_ack, wr_err, mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_wdata, mem_rdata;
    logic [2:0]    color;
    logic          de, hsync, vsync, frame_start;

    int n_chk = 0;
    int n_fail = 0;

    pixel_scheduler #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pix_en(pix_en),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_color(wr_color),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .color(color), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Frame buffer: unwritten locations hold addr[2:0]
    bit       mem_w [64];
    bit [2:0] mem_v [64];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_w[mem_addr] <= 1'b1;
            mem_v[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_w[mem_addr] ? mem_v[mem_addr] : mem_addr[2:0];
    end

    // Reference model
    typedef struct { int due; bit de; bit hs; bit vs; bit fs; int col; } ent_t;
    ent_t     q[$];
    int       cyc = 0;
    int       pidx = 0;
    bit       running = 1'b0;
    bit       ref_w [FB];
    bit [2:0] ref_v [FB];
    int       e_color = 0;
    bit       e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;

    function automatic bit is_act(input int k);
        return ((k % HT) < HA) && ((k / HT) < VA);
    endfunction

    function automatic int ref_fb(input int a);
        return ref_w[a] ? int'(ref_v[a]) : (a % 8);
    endfunction

    always @(negedge clk) begin : model
        int h, v, ea, ewd;
        bit srd, eack, eerr, ewe;
        ent_t e;
        h = pidx % HT;
        v = pidx / HT;
        srd = !reset && running && pix_en && is_act(pidx);
        eack = 0; eerr = 0; ewe = 0; ea = 0; ewd = 0;
        if (!reset) begin
            if (srd) begin
                ea = v * HA + h;
            end else if (wr_req) begin
                eack = 1;
                if (int'(wr_addr) < FB) begin
                    ewe = 1; ea = int'(wr_addr); ewd = int'(wr_color);
                end else begin
                    eerr = 1;
                end
            end
        end
        chk("wr_ack", wr_ack, eack);
        chk("wr_err", wr_err, eerr);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("color", color, e_color);
        chk("de", de, e_de);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", frame_start, e_fs);

        e_fs = 0;
        if (reset) begin
            running = 0; pidx = 0; q.delete();
            e_color = 0; e_de = 0; e_hs = 1; e_vs = 1;
        end else begin
            while (q.size() > 0 && q[0].due == cyc + 1) begin
                e = q.pop_front();
                e_de = e.de; e_hs = e.hs; e_vs = e.vs; e_fs = e.fs; e_color = e.col;
            end
            if (ewe) begin
                ref_w[ea] = 1'b1;
                ref_v[ea] = 3'(ewd);
            end
            if (running && pix_en) begin
                e.due = cyc + 2;
                e.de  = is_act(pidx);
                e.hs  = !(h >= HSS && h < HSE);
                e.vs  = !(v >= VSS && v < VSE);
                e.fs  = (pidx == 0);
                e.col = e.de ? ref_fb(v * HA + h) : 0;
                q.push_back(e);
                if (pidx == N - 1 && !enable) running = 0;
                pidx = (pidx + 1) % N;
            end else if (!running && pix_en && enable) begin
                running = 1;
            end
        end
        cyc++;
    end

    // Stimulus
    int pmode = 1;
    bit drop = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (drop) begin
            wr_req = 1'b0;
            drop = 1'b0;
        end
        case (pmode)
            1:       pix_en = ~pix_en;
            2:       pix_en = pix_en ? 1'b0 : 1'($urandom_range(0, 1));
            default: pix_en = 1'b0;
        endcase
    endtask

    task automatic do_write(input int a, input int c, input bit err_exp, input string nm);
        int lat;
        bit got;
        step();
        wr_req = 1'b1; wr_addr = AW'(a); wr_color = 3'(c);
        lat = 0; got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (wr_ack) begin
                got = 1;
                chk({nm, "_err"}, wr_err, err_exp);
                chk({nm, "_we"}, mem_we, !err_exp);
                chk({nm, "_lat_le2"}, lat <= 2, 1);
            end else begin
                step();
            end
        end
        if (!got) chk({nm, "_ack_timeout"}, 0, 1);
        drop = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_de, cnt_hs, cnt_vs, cnt_bad, cnt_fs, lat;
        bit found, rst_in;
        reset = 1; enable = 0; pix_en = 0;
        wr_req = 1; wr_addr = AW'(39); wr_color = 3'd5;

        // Reset with writer pending and pix_en toggling
        repeat (3) begin
            step();
            @(negedge clk);
            chk("rst_ack", wr_ack, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_de", de, 0);
            chk("rst_hsync", hsync, 1);
            chk("rst_vsync", vsync, 1);
            chk("rst_color", color, 0);
        end
        step();
        reset = 0;
        @(negedge clk);
        chk("post_rst_ack", wr_ack, 1);
        chk("post_rst_addr", mem_addr, 39);
        drop = 1;

        // Scan with pix_en every 2nd cycle
        enable = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            @(negedge clk);
            if (frame_start) found = 1;
        end
        chk("scan_fs_seen", found, 1);
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_bad = 0; cnt_fs = 0;
        for (int j = 0; j < 2 * N; j++) begin
            if (de) cnt_de++;
            if (!hsync) cnt_hs++;
            if (!vsync) cnt_vs++;
            if (de && (!hsync || !vsync)) cnt_bad++;
            if (frame_start) cnt_fs++;
            if (j % 2 == 0 && j / 2 < HA) begin
                chk("line0_de", de, 1);
                chk("line0_color", color, j / 2);
            end
            step();
            @(negedge clk);
        end
        chk("frame_de_cycles", cnt_de, 80);
        chk("frame_hsync_low", cnt_hs, 54);
        chk("frame_vsync_low", cnt_vs, 56);
        chk("de_in_sync", cnt_bad, 0);
        chk("fs_per_frame", cnt_fs, 1);
        chk("fs_next_frame", frame_start, 1);

        // Write colliding with an active scan read
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (pix_en && running && is_act(pidx)) found = 1;
        end
        chk("conflict_slot", found, 1);
        wr_req = 1; wr_addr = AW'(5); wr_color = 3'b110;
        @(negedge clk);
        chk("conflict_ack0", wr_ack, 0);
        step();
        @(negedge clk);
        chk("conflict_ack1", wr_ack, 1);
        chk("conflict_we", mem_we, 1);
        chk("conflict_addr", mem_addr, 5);
        chk("conflict_wdata", mem_wdata, 6);
        drop = 1;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            @(negedge clk);
            if (frame_start) found = 1;
        end
        chk("conflict_fs_seen", found, 1);
        repeat (10) begin
            step();
            @(negedge clk);
        end
        chk("readback_de", de, 1);
        chk("readback_color", color, 6);

        // Range boundary
        do_write(FB, 3, 1, "range_40");
        do_write(63, 1, 1, "range_63");
        do_write(FB - 1, 7, 0, "range_39");

        // Randomised traffic with a mid-frame reset
        pmode = 2;
        lat = 0; rst_in = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            if (i == 900) reset = 1;
            if (i == 902) reset = 0;
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1;
                wr_addr = AW'($urandom_range(0, 63));
                wr_color = 3'($urandom_range(0, 7));
                lat = 0; rst_in = 0;
            end
            @(negedge clk);
            if (reset) rst_in = 1;
            if (wr_req && !drop) begin
                lat++;
                if (wr_ack) begin
                    if (!rst_in) chk("rnd_lat_le2", lat <= 2, 1);
                    drop = 1;
                end
            end
        end

        // Enable dropped mid-frame: frame completes, then idle
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (running && pidx / HT == 3) found = 1;
        end
        chk("en_drop_slot", found, 1);
        enable = 0;
        cnt_fs = 0;
        found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            step();
            if (!running) begin
                found = 1;
            end else begin
                @(negedge clk);
                if (frame_start) cnt_fs++;
            end
        end
        chk("en_idle_reached", found, 1);
        chk("en_fs_before_idle", cnt_fs, 0);
        cnt_fs = 0;
        repeat (300) begin
            step();
            @(negedge clk);
            if (frame_start) cnt_fs++;
        end
        chk("en_fs_after_idle", cnt_fs, 0);
        chk("en_idle_de", de, 0);
        do_write(12, 4, 0, "idle_write");
        step();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
